// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin arbiter slice.
package arb_pkg;

  localparam int ARB_N        = 8;
  localparam int ARB_CODE_W   = $clog2(ARB_N);
  localparam int ARB_MAX_HOLD = 16;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating-priority picker: ptr is the highest-priority index, then ptr-1
// downwards with wrap-around. The request vector is rotated so that req[ptr]
// lands on the top bit, then a plain highest-bit-wins encoder picks the winner.
module rr_prio_pick
  import arb_pkg::*;
#(
  parameter int N      = ARB_N,
  parameter int CODE_W = $clog2(N)
) (
  input  logic [N-1:0]      req,
  input  logic [CODE_W-1:0] ptr,
  output logic              found,
  output logic [CODE_W-1:0] idx
);

  logic [N-1:0] rotated;
  int           top_pos;
  int           wrapped;

  // Bit b of the rotated vector holds req[(b + ptr + 1) mod N], so req[ptr]
  // sits at bit N-1 and req[ptr+1] (the lowest priority) sits at bit 0.
  function automatic logic [N-1:0] rotate_req(input logic [N-1:0] r,
                                               input logic [CODE_W-1:0] p);
    logic [N-1:0] rot;
    int           src;
    rot = '0;
    for (int b = 0; b < N; b++) begin
      src = b + int'(p) + 1;
      if (src >= N) src = src - N;
      rot[b] = r[CODE_W'(src)];
    end
    return rot;
  endfunction

  // Find the highest set bit of the rotated vector and map it back to a
  // requester index by undoing the rotation.
  always_comb begin
    rotated = rotate_req(req, ptr);
    found   = |rotated;
    top_pos = 0;
    for (int b = 0; b < N; b++) begin
      if (rotated[b]) top_pos = b;
    end
    wrapped = top_pos + int'(ptr) + 1;
    if (wrapped >= N) wrapped = wrapped - N;
    idx = CODE_W'(wrapped);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks one requester by rotating priority, holds the
// grant until the owner drops its request or the hold limit forces a release,
// then spends one idle cycle before the next arbitration.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int CODE_W   = $clog2(N),
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N-1:0]      req,
  output logic [N-1:0]      gnt,
  output logic [CODE_W-1:0] gnt_code,
  output logic              gnt_valid,
  output logic              timeout
);

  localparam int                HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [CODE_W-1:0] PTR_INIT  = CODE_W'(N - 1);

  arb_state_t        state_q, state_d;
  logic [CODE_W-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [CODE_W-1:0] gnt_code_q, gnt_code_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              timeout_q, timeout_d;

  logic              pick_found;
  logic [CODE_W-1:0] pick_idx;
  logic              owner_req;
  logic              limit_hit;

  rr_prio_pick #(
    .N      (N),
    .CODE_W (CODE_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state logic: issue a grant from IDLE, or count/release while granted.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_code_d  = gnt_code_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    owner_req   = req[gnt_code_q];
    limit_hit   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

    case (state_q)
      IDLE: begin
        if (en && pick_found) begin
          state_d     = GRANT;
          gnt_d       = N'(1) << pick_idx;
          gnt_code_d  = pick_idx;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      GRANT: begin
        if (!owner_req || limit_hit) begin
          // A voluntary drop on the limit cycle is a normal release, so the
          // timeout flag only fires when the owner still wanted the resource.
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_code_d  = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
          timeout_d   = owner_req;
          ptr_d       = (gnt_code_q == '0) ? PTR_INIT : gnt_code_q - CODE_W'(1);
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, counter and registered outputs; reset clears all at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= PTR_INIT;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_code_q  <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_code_q  <= gnt_code_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_code  = gnt_code_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Testbench for rr_arbiter: directed scenarios plus randomized traffic, all
// checked against an ownership-level model of the arbiter.
module tb_rr_arbiter;

  localparam int N  = 8;
  localparam int CW = 3;
  localparam int MH = 4;

  logic          clk;
  logic          rst;
  logic          en;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [CW-1:0] gnt_code;
  logic          gnt_valid;
  logic          timeout;

  int n_vec;
  int n_err;

  // Reference model: who owns the resource, for how many cycles, and which
  // index currently has top priority.
  int   m_owner;
  int   m_held;
  int   m_ptr;
  logic m_timeout;

  logic [12:0] obs;

  rr_arbiter #(
    .N        (N),
    .CODE_W   (CW),
    .MAX_HOLD (MH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_code  (gnt_code),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Walk the priority order ptr, ptr-1, ... with wrap and return the first requester.
  function automatic int ref_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p - k + N) % N;
      if (((r >> i) & N'(1)) != '0) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_held    = 0;
    m_ptr     = N - 1;
    m_timeout = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_step(input logic [N-1:0] r, input logic e);
    int   w;
    logic own;
    m_timeout = 1'b0;
    if (m_owner < 0) begin
      w = ref_pick(r, m_ptr);
      if (e && w >= 0) begin
        m_owner = w;
        m_held  = 1;
      end
    end else begin
      own = ((r >> m_owner) & N'(1)) != '0;
      if (!own || m_held >= MH) begin
        m_timeout = own;
        m_ptr     = (m_owner + N - 1) % N;
        m_owner   = -1;
        m_held    = 0;
      end else begin
        m_held++;
      end
    end
  endtask

  // Expected {gnt, gnt_code, gnt_valid, timeout} from the model.
  function automatic logic [12:0] model_out();
    logic [N-1:0]  g;
    logic [CW-1:0] c;
    g = '0;
    c = '0;
    if (m_owner >= 0) begin
      g = N'(1) << m_owner;
      c = CW'(m_owner);
    end
    return {g, c, (m_owner >= 0), m_timeout};
  endfunction

  // Drive one cycle of inputs, let the edge happen, step the model, sample 1ns later.
  task automatic apply_stimulus(input logic [N-1:0] r, input logic e);
    req = r;
    en  = e;
    @(posedge clk);
    model_step(r, e);
    #1;
    obs = {gnt, gnt_code, gnt_valid, timeout};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    en  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Reset values, asynchronous clear in the middle of a grant, and the
  // pointer starting point after reset.
  task automatic test_reset();
    @(posedge clk);
    #1;
    n_vec++;
    if ({gnt, gnt_code, gnt_valid, timeout} !== 13'h0) begin
      n_err++;
      $display("[TB] FAIL reset_idle: got %h want %h", {gnt, gnt_code, gnt_valid, timeout}, 13'h0);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(8'h10, 1'b1);
      n_vec++;
      if (obs !== model_out()) begin
        n_err++;
        $display("[TB] FAIL reset_pregrant cyc %0d: got %h want %h", i, obs, model_out());
      end
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({gnt, gnt_code, gnt_valid, timeout} !== 13'h0) begin
      n_err++;
      $display("[TB] FAIL reset_async: got %h want %h", {gnt, gnt_code, gnt_valid, timeout}, 13'h0);
    end
    #2;
    rst = 1'b0;
    model_reset();
    apply_stimulus(8'h01, 1'b1);
    n_vec++;
    if (obs !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL reset_regrant: got %h want %h", obs, {8'h01, 3'd0, 1'b1, 1'b0});
    end
    apply_stimulus(8'h00, 1'b1);
    n_vec++;
    if (obs !== model_out()) begin
      n_err++;
      $display("[TB] FAIL reset_release: got %h want %h", obs, model_out());
    end
  endtask

  // Highest index wins from reset; releasing hands over after one idle cycle.
  task automatic test_fixed_start();
    logic [N-1:0] r_seq[4] = '{8'h81, 8'h01, 8'h01, 8'h00};
    logic [12:0]  e_seq[4] = '{{8'h80, 3'd7, 1'b1, 1'b0}, 13'h0,
                               {8'h01, 3'd0, 1'b1, 1'b0}, 13'h0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(r_seq[i], 1'b1);
      n_vec++;
      if (obs !== e_seq[i] || obs !== model_out()) begin
        n_err++;
        $display("[TB] FAIL fixed_start cyc %0d: got %h want %h", i, obs, e_seq[i]);
      end
    end
  endtask

  // All requesting; each owner drops briefly after two cycles so ownership rotates.
  task automatic test_rotation();
    int           order[$];
    int           exp_order[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int           idle_run;
    logic         prev_valid;
    logic [N-1:0] r;
    do_reset();
    idle_run   = 0;
    prev_valid = 1'b0;
    for (int cyc = 0; cyc < 80 && order.size() < 9; cyc++) begin
      r = 8'hFF;
      if (m_owner >= 0 && m_held == 2) r = ~(N'(1) << m_owner);
      apply_stimulus(r, 1'b1);
      n_vec++;
      if (obs !== model_out()) begin
        n_err++;
        $display("[TB] FAIL rotation cyc %0d: got %h want %h", cyc, obs, model_out());
      end
      if (!gnt_valid) begin
        idle_run++;
      end else begin
        if (!prev_valid) begin
          if (order.size() > 0) begin
            n_vec++;
            if (idle_run != 1) begin
              n_err++;
              $display("[TB] FAIL rotation_gap: got %0d idle cycles want 1", idle_run);
            end
          end
          order.push_back(int'(gnt_code));
        end
        idle_run = 0;
      end
      prev_valid = gnt_valid;
    end
    n_vec++;
    if (order.size() != 9) begin
      n_err++;
      $display("[TB] FAIL rotation_count: got %0d grants want 9", order.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_vec++;
        if (order[i] != exp_order[i]) begin
          n_err++;
          $display("[TB] FAIL rotation_order idx %0d: got %0d want %0d", i, order[i], exp_order[i]);
        end
      end
    end
  endtask

  // Hold limit with a competitor waiting, and with a sole requester.
  task automatic test_hold_limit();
    logic [N-1:0] g_two[6]  = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h08};
    logic         t_two[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [N-1:0] g_sole[7] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h08, 8'h08};
    logic         t_sole[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(8'h28, 1'b1);
      n_vec++;
      if ({gnt, timeout} !== {g_two[i], t_two[i]} || obs !== model_out()) begin
        n_err++;
        $display("[TB] FAIL hold_limit_pair cyc %0d: got %h want %h", i, obs, model_out());
      end
    end
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(8'h08, 1'b1);
      n_vec++;
      if ({gnt, timeout} !== {g_sole[i], t_sole[i]} || obs !== model_out()) begin
        n_err++;
        $display("[TB] FAIL hold_limit_sole cyc %0d: got %h want %h", i, obs, model_out());
      end
    end
  endtask

  // Owner drops on the very cycle the limit is reached: plain release, no timeout.
  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(8'h20, 1'b1);
      n_vec++;
      if (obs !== {8'h20, 3'd5, 1'b1, 1'b0}) begin
        n_err++;
        $display("[TB] FAIL simul_hold cyc %0d: got %h want %h", i, obs, {8'h20, 3'd5, 1'b1, 1'b0});
      end
    end
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(8'h00, 1'b1);
      n_vec++;
      if (obs !== 13'h0 || obs !== model_out()) begin
        n_err++;
        $display("[TB] FAIL simul_release cyc %0d: got %h want %h", i, obs, 13'h0);
      end
    end
  endtask

  // Enable blocks new grants only; a running grant ignores it.
  task automatic test_enable();
    logic [N-1:0] r_seq[8] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00};
    logic         e_seq[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [N-1:0] g_seq[8] = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(r_seq[i], e_seq[i]);
      n_vec++;
      if (gnt !== g_seq[i] || obs !== model_out()) begin
        n_err++;
        $display("[TB] FAIL enable cyc %0d: got %h want %h", i, obs, model_out());
      end
    end
  endtask

  // Random traffic with sticky requests, random enable and occasional
  // asynchronous resets, checked cycle by cycle plus output invariants.
  task automatic test_random();
    logic [N-1:0] r;
    logic         e;
    do_reset();
    r = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if ($urandom_range(0, 9) < 3) r = N'($urandom);
      e = ($urandom_range(0, 9) < 8);
      apply_stimulus(r, e);
      n_vec++;
      if (obs !== model_out()) begin
        n_err++;
        $display("[TB] FAIL random cyc %0d: got %h want %h", cyc, obs, model_out());
      end
      n_vec++;
      if (!$onehot0(gnt) || gnt_valid !== (|gnt) ||
          (gnt_valid && gnt !== (N'(1) << gnt_code)) || (!gnt_valid && gnt_code !== '0)) begin
        n_err++;
        $display("[TB] FAIL invariant cyc %0d: gnt %h code %0d valid %b", cyc, gnt, gnt_code, gnt_valid);
      end
      if ($urandom_range(0, 99) < 2) begin
        rst = 1'b1;
        #1;
        n_vec++;
        if ({gnt, gnt_code, gnt_valid, timeout} !== 13'h0) begin
          n_err++;
          $display("[TB] FAIL random_reset cyc %0d: got %h want %h", cyc, {gnt, gnt_code, gnt_valid, timeout}, 13'h0);
        end
        rst = 1'b0;
        model_reset();
      end
    end
  endtask

  // Run every scenario in order and report.
  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    en    = 1'b0;
    req   = '0;
    obs   = '0;
    model_reset();
    test_reset();
    test_fixed_start();
    test_rotation();
    test_hold_limit();
    test_simultaneous();
    test_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
